// File: rtl/dnn_result_monitor.sv
// dnn_result_monitor
//   Output-side scoreboard for the DNN training loop. Deserializes the
//   ideal-output stream over one block cycle, compares it with the
//   thresholded network output, and keeps running accuracy statistics.
//
// Ports
//   clk            in   clock, rising edge
//   reset          in   synchronous, active-high
//   cycle_index    in   position within the block cycle
//   y_out          in   ideal-output chunk for the current position
//   a_out          in   thresholded network output (sampled on compare edge)
//   result_valid   out  one-cycle pulse when a case is scored
//   correct        out  score of the last case (1 = all neurons match)
//   recent         out  correct cases among the last checklast cases
//   total_correct  out  cumulative correct cases (saturating)
//   case_count     out  number of cases scored
//   epoch          out  current epoch, 1-based
//   epoch_done     out  pulses with result_valid on the last case of an epoch
module dnn_result_monitor #(
    parameter int n_out          = 16,
    parameter int y_per_clk      = 1,
    parameter int cpc            = 18,
    parameter int checklast      = 1000,
    parameter int training_cases = 10000,
    parameter int cnt_width      = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [$clog2(cpc)-1:0]           cycle_index,
    input  logic [y_per_clk-1:0]             y_out,
    input  logic [n_out-1:0]                 a_out,
    output logic                             result_valid,
    output logic                             correct,
    output logic [$clog2(checklast+1)-1:0]   recent,
    output logic [cnt_width-1:0]             total_correct,
    output logic [cnt_width-1:0]             case_count,
    output logic [cnt_width-1:0]             epoch,
    output logic                             epoch_done
);

    localparam int CIW  = $clog2(cpc);
    localparam int RW   = $clog2(checklast + 1);
    localparam int PW   = (checklast > 1) ? $clog2(checklast) : 1;
    localparam int EW   = (training_cases > 1) ? $clog2(training_cases) : 1;
    // The final chunk is merged live on the compare edge, so only the
    // chunks at positions 2 .. cpc-2 need storage.
    localparam int NCAP = cpc - 3;
    localparam int IW   = n_out - y_per_clk;

    localparam logic [cnt_width-1:0] CNT_ONE = {{(cnt_width-1){1'b0}}, 1'b1};

    logic [IW-1:0]        r_ideal;
    logic                 r_armed;
    logic [checklast-1:0] r_hist;
    logic [PW-1:0]        r_ptr;
    logic [EW-1:0]        r_in_epoch;
    logic [RW-1:0]        r_recent;
    logic [cnt_width-1:0] r_total;
    logic [cnt_width-1:0] r_case;
    logic [cnt_width-1:0] r_epoch;
    logic                 r_correct;
    logic                 r_valid;
    logic                 r_epoch_done;

    logic w_last;
    logic w_compare;
    logic w_match;

    assign w_last    = (cycle_index == CIW'(cpc - 1));
    assign w_compare = w_last && r_armed;
    assign w_match   = ({y_out, r_ideal} == a_out);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ideal      <= '0;
            r_armed      <= 1'b0;
            r_hist       <= '0;
            r_ptr        <= '0;
            r_in_epoch   <= '0;
            r_recent     <= '0;
            r_total      <= '0;
            r_case       <= '0;
            r_epoch      <= CNT_ONE;
            r_correct    <= 1'b0;
            r_valid      <= 1'b0;
            r_epoch_done <= 1'b0;
        end else begin
            r_valid      <= 1'b0;
            r_epoch_done <= 1'b0;

            for (int unsigned k = 0; k < NCAP; k++) begin
                if (cycle_index == CIW'(k + 2))
                    r_ideal[k*y_per_clk +: y_per_clk] <= y_out;
            end

            if (cycle_index == CIW'(2))
                r_armed <= 1'b1;

            if (w_compare) begin
                r_armed   <= 1'b0;
                r_correct <= w_match;
                r_valid   <= 1'b1;

                // Oldest score leaves the window as the new one enters.
                r_recent      <= r_recent - RW'(r_hist[r_ptr]) + RW'(w_match);
                r_hist[r_ptr] <= w_match;
                if (r_ptr == PW'(checklast - 1))
                    r_ptr <= '0;
                else
                    r_ptr <= r_ptr + PW'(1);

                r_case <= r_case + CNT_ONE;
                if (w_match && (r_total != '1))
                    r_total <= r_total + CNT_ONE;

                if (r_in_epoch == EW'(training_cases - 1)) begin
                    r_in_epoch   <= '0;
                    r_epoch_done <= 1'b1;
                    r_epoch      <= r_epoch + CNT_ONE;
                end else begin
                    r_in_epoch <= r_in_epoch + EW'(1);
                end
            end
        end
    end

    assign result_valid  = r_valid;
    assign correct       = r_correct;
    assign recent        = r_recent;
    assign total_correct = r_total;
    assign case_count    = r_case;
    assign epoch         = r_epoch;
    assign epoch_done    = r_epoch_done;

endmodule

// File: tb/tb_dnn_result_monitor.sv
// tb_dnn_result_monitor
//   Table-driven bench for dnn_result_monitor with a small window (4) and
//   short epochs (3 cases), plus hand-written reset corner sequences.
module tb_dnn_result_monitor;

    localparam int N_OUT = 16;
    localparam int CPC   = 18;

    logic        clk;
    logic        reset;
    logic [4:0]  cycle_index;
    logic [0:0]  y_out;
    logic [15:0] a_out;
    logic        result_valid;
    logic        correct;
    logic [2:0]  recent;
    logic [31:0] total_correct;
    logic [31:0] case_count;
    logic [31:0] epoch;
    logic        epoch_done;

    int n_err;
    int n_checks;

    dnn_result_monitor #(
        .n_out          (N_OUT),
        .y_per_clk      (1),
        .cpc            (CPC),
        .checklast      (4),
        .training_cases (3),
        .cnt_width      (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cycle_index   (cycle_index),
        .y_out         (y_out),
        .a_out         (a_out),
        .result_valid  (result_valid),
        .correct       (correct),
        .recent        (recent),
        .total_correct (total_correct),
        .case_count    (case_count),
        .epoch         (epoch),
        .epoch_done    (epoch_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] id;
        logic [15:0] a;
        logic        c;
        int          r;
        int          t;
        int          n;
        int          e;
        logic        d;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one block cycle; counts result_valid pulses seen after every
    // edge except the final compare edge. rst_at < 0 means no reset.
    task automatic run_block(input logic [15:0] id, input logic [15:0] a,
                             input int first_ci, input int rst_at, output int early);
        early = 0;
        for (int ci = first_ci; ci < CPC; ci++) begin
            cycle_index = 5'(ci);
            y_out       = (ci >= 2) ? id[ci-2] : 1'b0;
            a_out       = a;
            reset       = (ci == rst_at);
            @(posedge clk);
            #1;
            if (ci < CPC - 1 && result_valid) early++;
        end
        reset = 1'b0;
    endtask

    task automatic chk_stats(input string tag, input logic rv, input logic c, input int r,
                             input int t, input int n, input int e, input logic d);
        chk({tag, ".valid"}, 32'(result_valid), 32'(rv));
        chk({tag, ".correct"}, 32'(correct), 32'(c));
        chk({tag, ".recent"}, 32'(recent), r);
        chk({tag, ".total"}, total_correct, t);
        chk({tag, ".cases"}, case_count, n);
        chk({tag, ".epoch"}, epoch, e);
        chk({tag, ".epoch_done"}, 32'(epoch_done), 32'(d));
    endtask

    initial begin
        int early;
        n_err    = 0;
        n_checks = 0;

        tbl[0] = '{16'h0004, 16'h0004, 1'b1, 1, 1, 1, 1, 1'b0};
        tbl[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 2, 2, 2, 1, 1'b0};
        tbl[2] = '{16'h1234, 16'h1234, 1'b1, 3, 3, 3, 2, 1'b1};
        tbl[3] = '{16'h8001, 16'h8001, 1'b1, 4, 4, 4, 2, 1'b0};
        tbl[4] = '{16'h8004, 16'h0004, 1'b0, 3, 4, 5, 2, 1'b0};
        tbl[5] = '{16'h0001, 16'h0000, 1'b0, 2, 4, 6, 3, 1'b1};
        tbl[6] = '{16'h0000, 16'h0000, 1'b1, 2, 5, 7, 3, 1'b0};

        // Reset held for 3 clocks.
        reset       = 1'b1;
        cycle_index = '0;
        y_out       = '0;
        a_out       = '0;
        for (int i = 0; i < 3; i++) begin
            cycle_index = 5'(i);
            @(posedge clk);
            #1;
        end
        chk_stats("reset", 1'b0, 1'b0, 0, 0, 0, 1, 1'b0);
        reset = 1'b0;

        // Partial block that never passes position 2: no compare.
        run_block(16'h0000, 16'h0000, 10, -1, early);
        chk("partial.early", early, 0);
        chk("partial.valid", 32'(result_valid), 0);
        chk("partial.cases", case_count, 0);

        // Window wrap and epoch boundaries.
        for (int v = 0; v < 7; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            run_block(tbl[v].id, tbl[v].a, 0, -1, early);
            chk({tag, ".early"}, early, 0);
            chk_stats(tag, 1'b1, tbl[v].c, tbl[v].r, tbl[v].t, tbl[v].n, tbl[v].e, tbl[v].d);
        end

        // Reset mid-block after 2 scored cases.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_block(16'h0F0F, 16'h0F0F, 0, -1, early);
        run_block(16'h00FF, 16'h00FF, 0, -1, early);
        chk("pre_rst.cases", case_count, 2);
        run_block(16'h3C3C, 16'h3C3C, 0, 9, early);
        chk("midrst.early", early, 0);
        chk_stats("midrst", 1'b0, 1'b0, 0, 0, 0, 1, 1'b0);
        run_block(16'h00F0, 16'h00F0, 0, -1, early);
        chk("after_rst.early", early, 0);
        chk_stats("after_rst", 1'b1, 1'b1, 1, 1, 1, 1, 1'b0);

        // Reset coinciding with the compare edge wins.
        run_block(16'h5555, 16'h5555, 0, CPC - 1, early);
        chk_stats("rst_cmp", 1'b0, 1'b0, 0, 0, 0, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/dnn_result_monitor.md
# dnn_result_monitor

Synthesizable output-side scoreboard for the DNN training loop. It sits after the `DNN` output ports: it deserializes the ideal-output stream `y_out` over one block cycle, compares it with the thresholded output vector `a_out_alln`, and keeps running accuracy statistics in hardware. Statistics cover per-case correctness, a sliding-window count, a cumulative total and an epoch count, so accuracy can be read without simulation-only probes.

## Interface

Parameters:

- `n_out`, 16: number of output neurons (`n[L-1]`).
- `y_per_clk`, 1: ideal-output bits delivered per clock (`z[L-2]/fi[L-2]`).
- `cpc`, 18: clocks per block cycle. Requires `n_out == (cpc-2)*y_per_clk`.
- `checklast`, 1000: sliding-window depth, in cases.
- `training_cases`, 10000: cases per epoch.
- `cnt_width`, 32: width of the case, total and epoch counters.

Ports (one clock; reset is synchronous and active-high):

- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `cycle_index`, in, `$clog2(cpc)`: position within the block cycle, from `cycle_block_counter`.
- `y_out`, in, `y_per_clk`: ideal-output chunk for the current position.
- `a_out`, in, `n_out`: thresholded network output, all neurons.
- `result_valid`, out, 1: one-cycle pulse when a case is scored.
- `correct`, out, 1: score of the last case (1 = all neurons match).
- `recent`, out, `$clog2(checklast+1)`: number of correct cases in the last `checklast` cases.
- `total_correct`, out, `cnt_width`: cumulative number of correct cases.
- `case_count`, out, `cnt_width`: number of cases scored.
- `epoch`, out, `cnt_width`: current epoch, 1-based.
- `epoch_done`, out, 1: pulses together with `result_valid` on the last case of an epoch.

## Operation

- **Capture.** On each edge where `cycle_index >= 2`, write `y_out` into `ideal[(cycle_index-2)*y_per_clk +: y_per_clk]`.
  - When `cycle_index == 2`, also set the `armed` flag.
  - Positions 0 and 1 are pipeline fill and are ignored.
- **Compare.** On the edge where `cycle_index == cpc-1` and `armed == 1`, compute `match = ({y_out, ideal[n_out-1-y_per_clk:0]} == a_out)`, using the merged final chunk. On the same edge:
  - Register `correct <= match` and assert `result_valid`.
  - Clear `armed`.
- **Window.** A circular bit buffer `hist[checklast-1:0]` with pointer `ptr` tracks the last `checklast` scores. On each compare:
  - `recent <= recent - hist[ptr] + match`, then `hist[ptr] <= match`.
  - `ptr` wraps from `checklast-1` to 0.
  - `recent` never exceeds `checklast`.
- **Totals.**
  - `case_count` increments by 1 per compare.
  - `total_correct` increments by `match`; it saturates at all-ones and is never cleared by an epoch boundary.
- **Epoch.** An internal `in_epoch` counter runs 0 to `training_cases-1`. On the compare where it equals `training_cases-1`:
  - Wrap it to 0.
  - Pulse `epoch_done` and increment `epoch`.
- **Reset.** Asserting `reset` (on any cycle) synchronously clears all state:
  - `ideal`, `hist`, `ptr`, `armed`, `in_epoch`, `recent`, `total_correct`, `case_count`, `correct`, `result_valid` and `epoch_done` all go to 0.
  - `epoch` goes to 1.
  - A partially captured block is discarded. No compare happens until a new `cycle_index == 2` capture re-arms the block.

## Timing

- `result_valid`, `correct`, `recent`, `total_correct`, `case_count`, `epoch` and `epoch_done` all update on the same edge: the one that samples `cycle_index == cpc-1`. They are visible while `cycle_index == 0`.
- `result_valid` and `epoch_done` are high for exactly one clock.
- Latency from the final `y_out` chunk to the score is 1 clock.
- Throughput is one case per `cpc` clocks.
- Sample-time rule: `a_out` is sampled only on the compare edge and must be stable there.
- If `cycle_index` jumps to `cpc-1` without passing position 2 (`armed == 0`), no compare occurs.
- If `reset` and a compare edge coincide, reset wins and no pulse is generated.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- **Reset values.** Hold `reset` for 3 clocks → all outputs 0, `epoch == 1`, no `result_valid` during the first partial block.
- **Matching case.** Use `a_out = 16'h0004` and serialize bit 2 = 1 at `cycle_index == 4`, all other chunks 0 → one `result_valid` pulse at `cycle_index == 0`, with `correct = 1`, `recent = 1`, `total_correct = 1`, `case_count = 1`.
- **Mismatch in last chunk.** Identical to the matching case except `y_out = 1` at `cycle_index == 17` (bit 15) → `correct = 0`, `recent` and `total_correct` unchanged, `case_count` +1.
- **Window wrap.** With `checklast = 4`, feed scores 1,1,1,1,0,0,1 → `recent` reads 1,2,3,4,3,2,2.
- **Epoch boundary.** With `training_cases = 3`, feed 7 cases → `epoch_done` pulses on cases 3 and 6, `epoch` reads 2 then 3, and `total_correct` continues across the boundaries.
- **Reset mid-block.** Pulse `reset` at `cycle_index == 9` after 2 scored cases → all statistics cleared, no pulse at the end of that block, and the next full block scores normally with `case_count = 1`.
